// File: rtl/dvi_raster_phy.sv
`default_nettype none
//============================================================================
// Module : dvi_raster_phy
// Desc   : 640x480@60 raster timing plus 10:1 TMDS serializer, all on the
//          serial bit clock with the pixel rate derived from a phase counter.
// Rev    : 1.0  initial release
//============================================================================
module dvi_raster_phy #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] red_tmds_i,
    input  logic [9:0] green_tmds_i,
    input  logic [9:0] blue_tmds_i,
    output logic       pixel_stb_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [9:0] pixel_x_o,
    output logic [9:0] pixel_y_o,
    output logic       visible_range_o,
    output logic [2:0] tmds_data_p,
    output logic [2:0] tmds_data_n,
    output logic       tmds_clk_p,
    output logic       tmds_clk_n
);

    localparam logic [3:0] c_PHASE_LAST = 4'd9;
    localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] c_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] c_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // Clock lane word: five ones then five zeros, sent LSB first.
    localparam logic [9:0] c_CLK_WORD   = 10'b00000_11111;

    logic [3:0] r_phase;
    logic       w_load;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_word [3];

    assign w_load = (r_phase == c_PHASE_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_phase <= 4'd0;
        end else if (w_load) begin
            r_phase <= 4'd0;
        end else begin
            r_phase <= r_phase + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else if (w_load) begin
            if (r_x == c_H_LAST) begin
                r_x <= 10'd0;
                r_y <= (r_y == c_V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign pixel_stb_o     = w_load;
    assign pixel_x_o       = r_x;
    assign pixel_y_o       = r_y;
    assign hsync_o         = !((r_x >= c_HS_START) && (r_x <= c_HS_END));
    assign vsync_o         = !((r_y >= c_VS_START) && (r_y <= c_VS_END));
    assign visible_range_o = (r_x < c_H_ACT) && (r_y < c_V_ACT);

    assign w_word[0] = blue_tmds_i;
    assign w_word[1] = green_tmds_i;
    assign w_word[2] = red_tmds_i;

    // Each lane: load on the pixel edge, shift right otherwise, and
    // register the LSB into the p/n pair so the pins are glitch free.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [9:0] r_sreg;
        logic       r_p;
        logic       r_n;

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                r_sreg <= 10'd0;
                r_p    <= 1'b0;
                r_n    <= 1'b1;
            end else begin
                r_sreg <= w_load ? w_word[gi] : (r_sreg >> 1);
                r_p    <= r_sreg[0];
                r_n    <= ~r_sreg[0];
            end
        end

        assign tmds_data_p[gi] = r_p;
        assign tmds_data_n[gi] = r_n;
    end

    logic [9:0] r_clk_sreg;
    logic       r_clk_p;
    logic       r_clk_n;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_clk_sreg <= 10'd0;
            r_clk_p    <= 1'b0;
            r_clk_n    <= 1'b1;
        end else begin
            r_clk_sreg <= w_load ? c_CLK_WORD : (r_clk_sreg >> 1);
            r_clk_p    <= r_clk_sreg[0];
            r_clk_n    <= ~r_clk_sreg[0];
        end
    end

    assign tmds_clk_p = r_clk_p;
    assign tmds_clk_n = r_clk_n;

endmodule
`default_nettype wire

// File: tb/tb_dvi_raster_phy.sv
`default_nettype none
//============================================================================
// Module : tb_dvi_raster_phy
// Desc   : Self-checking bench for dvi_raster_phy (short frame, full line).
// Rev    : 1.0  initial release
//============================================================================
module tb_dvi_raster_phy;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] red_tmds_i   = 10'd0;
    logic [9:0] green_tmds_i = 10'd0;
    logic [9:0] blue_tmds_i  = 10'd0;
    logic       pixel_stb_o, hsync_o, vsync_o, visible_range_o;
    logic [9:0] pixel_x_o, pixel_y_o;
    logic [2:0] tmds_data_p, tmds_data_n;
    logic       tmds_clk_p, tmds_clk_n;

    dvi_raster_phy #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .red_tmds_i(red_tmds_i), .green_tmds_i(green_tmds_i), .blue_tmds_i(blue_tmds_i),
        .pixel_stb_o(pixel_stb_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .visible_range_o(visible_range_o),
        .tmds_data_p(tmds_data_p), .tmds_data_n(tmds_data_n),
        .tmds_clk_p(tmds_clk_p), .tmds_clk_n(tmds_clk_n)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         e;
        logic [2:0] d;
        logic       c;
    } exp_t;
    exp_t sbq[$];
    exp_t m_ent;
    exp_t mon_ent;

    int tb_phase = 0;
    int tb_x = 0;
    int tb_y = 0;
    int edge_cnt = 0;

    // Reference model: raster counters and scoreboard pushes on load edges.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tb_phase = 0;
            tb_x     = 0;
            tb_y     = 0;
            edge_cnt = 0;
            sbq.delete();
        end else begin
            edge_cnt++;
            if (tb_phase == 9) begin
                for (int k = 0; k < 10; k++) begin
                    m_ent.e = edge_cnt + 1 + k;
                    m_ent.d = {red_tmds_i[k], green_tmds_i[k], blue_tmds_i[k]};
                    m_ent.c = (k < 5);
                    sbq.push_back(m_ent);
                end
                if (tb_x == HT - 1) begin
                    tb_x = 0;
                    tb_y = (tb_y == VT - 1) ? 0 : tb_y + 1;
                end else begin
                    tb_x++;
                end
                tb_phase = 0;
            end else begin
                tb_phase++;
            end
        end
    end

    logic [2:0] mon_d;
    logic       mon_c;

    always @(negedge clk_i) begin
        mon_d = 3'b000;
        mon_c = 1'b0;
        if (sbq.size() > 0 && sbq[0].e == edge_cnt) begin
            mon_ent = sbq.pop_front();
            mon_d   = mon_ent.d;
            mon_c   = mon_ent.c;
        end
        checks++;
        if ({tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n} !== {mon_d, ~mon_d, mon_c, ~mon_c}) begin
            errors++;
            $display("FAIL serial_lanes t=%0t got p=%b n=%b clk=%b/%b want p=%b n=%b clk=%b/%b",
                     $time, tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n,
                     mon_d, ~mon_d, mon_c, ~mon_c);
        end
    end

    task automatic step(input bit rnd);
        @(negedge clk_i);
        if (rnd) begin
            red_tmds_i   = 10'($urandom);
            green_tmds_i = 10'($urandom);
            blue_tmds_i  = 10'($urandom);
        end
    endtask

    task automatic wait_pos(input int x, input int y, input bit rnd);
        int n = 0;
        while (!(tb_x == x && tb_y == y) && n < 100000) begin
            step(rnd);
            n++;
        end
        if (n >= 100000) begin
            checks++;
            errors++;
            $display("FAIL wait_pos timeout got x=%0d y=%0d want x=%0d y=%0d", tb_x, tb_y, x, y);
        end
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n} !== 8'b000_111_0_1) begin
            errors++;
            $display("FAIL reset_lanes got %b want 00011101", {tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n});
        end
        checks++;
        if (pixel_x_o !== 10'd0 || pixel_y_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_xy got x=%0d y=%0d want 0 0", pixel_x_o, pixel_y_o);
        end
        checks++;
        if ({hsync_o, vsync_o, visible_range_o, pixel_stb_o} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_flags got %b want 1110", {hsync_o, vsync_o, visible_range_o, pixel_stb_o});
        end
    endtask

    task automatic test_strobe();
        #2 rst_i = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1'b1);
            checks++;
            if (pixel_stb_o !== ((k % 10) == 9)) begin
                errors++;
                $display("FAIL strobe cycle=%0d got %b want %b", k, pixel_stb_o, ((k % 10) == 9));
            end
        end
    endtask

    task automatic test_word_shape();
        logic [9:0] wb = 10'h2AA;
        logic [9:0] wg = 10'h3FF;
        logic [9:0] wr = 10'h001;
        int         k;
        logic [2:0] e;
        blue_tmds_i  = wb;
        green_tmds_i = wg;
        red_tmds_i   = wr;
        repeat (25) step(1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            k = (tb_phase + 9) % 10;
            e = {wr[k], wg[k], wb[k]};
            checks++;
            if (tmds_data_p !== e || tmds_data_n !== ~e) begin
                errors++;
                $display("FAIL word_shape bit=%0d got p=%b n=%b want p=%b n=%b", k, tmds_data_p, tmds_data_n, e, ~e);
            end
        end
    endtask

    task automatic test_clock_lane();
        int k;
        for (int i = 0; i < 30; i++) begin
            step(1'b1);
            k = (tb_phase + 9) % 10;
            checks++;
            if (tmds_clk_p !== (k < 5) || tmds_clk_n !== (k >= 5)) begin
                errors++;
                $display("FAIL clock_lane bit=%0d got p=%b n=%b want p=%b", k, tmds_clk_p, tmds_clk_n, (k < 5));
            end
        end
    endtask

    task automatic test_line_timing();
        wait_pos(639, 0, 1'b1);
        checks++;
        if (pixel_x_o !== 10'd639 || visible_range_o !== 1'b1) begin
            errors++;
            $display("FAIL vis_639 got x=%0d vis=%b want x=639 vis=1", pixel_x_o, visible_range_o);
        end
        wait_pos(640, 0, 1'b1);
        checks++;
        if (pixel_x_o !== 10'd640 || visible_range_o !== 1'b0) begin
            errors++;
            $display("FAIL vis_640 got x=%0d vis=%b want x=640 vis=0", pixel_x_o, visible_range_o);
        end
        wait_pos(655, 0, 1'b1);
        checks++;
        if (hsync_o !== 1'b1) begin errors++; $display("FAIL hsync_655 got %b want 1", hsync_o); end
        wait_pos(656, 0, 1'b1);
        checks++;
        if (hsync_o !== 1'b0) begin errors++; $display("FAIL hsync_656 got %b want 0", hsync_o); end
        wait_pos(751, 0, 1'b1);
        checks++;
        if (hsync_o !== 1'b0) begin errors++; $display("FAIL hsync_751 got %b want 0", hsync_o); end
        wait_pos(752, 0, 1'b1);
        checks++;
        if (hsync_o !== 1'b1) begin errors++; $display("FAIL hsync_752 got %b want 1", hsync_o); end
        wait_pos(799, 0, 1'b1);
        checks++;
        if (pixel_x_o !== 10'd799 || pixel_y_o !== 10'd0) begin
            errors++;
            $display("FAIL line_end got x=%0d y=%0d want 799 0", pixel_x_o, pixel_y_o);
        end
        wait_pos(0, 1, 1'b1);
        checks++;
        if (pixel_x_o !== 10'd0 || pixel_y_o !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap got x=%0d y=%0d want 0 1", pixel_x_o, pixel_y_o);
        end
    endtask

    task automatic test_frame_timing();
        int n = 0;
        int vs_low = 0;
        logic [24:0] got, want;
        do begin
            step(1'b1);
            n++;
            if (vsync_o === 1'b0) vs_low++;
            want = {10'(tb_x), 10'(tb_y),
                    !(tb_x >= H_ACTIVE + H_FP && tb_x <= H_ACTIVE + H_FP + H_SYNC - 1),
                    !(tb_y >= V_ACTIVE + V_FP && tb_y <= V_ACTIVE + V_FP + V_SYNC - 1),
                    (tb_x < H_ACTIVE) && (tb_y < V_ACTIVE),
                    (tb_phase == 9)};
            got = {pixel_x_o, pixel_y_o, hsync_o, vsync_o, visible_range_o, pixel_stb_o};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL raster got x=%0d y=%0d hs/vs/vis/stb=%b want x=%0d y=%0d hs/vs/vis/stb=%b",
                         got[24:15], got[14:5], got[4:1], want[24:15], want[14:5], want[4:1]);
            end
        end while (!(tb_x == 0 && tb_y == 0) && n < 70000);
        checks++;
        if (pixel_x_o !== 10'd0 || pixel_y_o !== 10'd0) begin
            errors++;
            $display("FAIL frame_wrap got x=%0d y=%0d want 0 0", pixel_x_o, pixel_y_o);
        end
        checks++;
        if (vs_low != V_SYNC * HT * 10) begin
            errors++;
            $display("FAIL vsync_len got %0d cycles want %0d", vs_low, V_SYNC * HT * 10);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (tb_phase != 4 && n < 50) begin
            step(1'b1);
            n++;
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n} !== 8'b000_111_0_1 ||
            pixel_x_o !== 10'd0 || pixel_y_o !== 10'd0 ||
            {hsync_o, vsync_o, visible_range_o, pixel_stb_o} !== 4'b1110) begin
            errors++;
            $display("FAIL mid_reset got lanes=%b x=%0d y=%0d flags=%b want 00011101 0 0 1110",
                     {tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n}, pixel_x_o, pixel_y_o,
                     {hsync_o, vsync_o, visible_range_o, pixel_stb_o});
        end
        blue_tmds_i  = 10'h155;
        green_tmds_i = 10'h0F0;
        red_tmds_i   = 10'h3C3;
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk_i);
            if (k == 10) begin
                checks++;
                if (tmds_data_p !== 3'b000) begin
                    errors++;
                    $display("FAIL restart_idle got p=%b want 000", tmds_data_p);
                end
            end
            if (k == 11) begin
                checks++;
                if (tmds_data_p !== 3'b101) begin
                    errors++;
                    $display("FAIL restart_bit0 got p=%b want 101", tmds_data_p);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_word_shape();
        test_clock_lane();
        test_line_timing();
        test_frame_timing();
        test_mid_reset();
        repeat (5) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvi_raster_phy.md
# dvi_raster_phy

Single-clock DVI raster and physical-layer block. It runs on the 10× serial bit clock and derives the pixel rate internally. It generates 640×480@60 raster timing (counters, syncs, visible flag) for the upstream pixel/TMDS-encoder logic. It serializes the three 10-bit TMDS words LSB-first onto registered pseudo-differential output pairs, together with a TMDS clock lane.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk_i  in  1  serial bit clock (10× pixel rate); the only clock
- rst_i  in  1  reset; asynchronous and active-low
- red_tmds_i / green_tmds_i / blue_tmds_i  in  10 each  TMDS words; sampled at the pixel load edge
- pixel_stb_o  out  1  high one cycle in ten; marks the pixel load edge
- hsync_o, vsync_o  out  1  active-low syncs
- pixel_x_o, pixel_y_o  out  10 each  raster position
- visible_range_o  out  1  high while the position is inside the active area
- tmds_data_p / tmds_data_n  out  3  lane 0 = blue, 1 = green, 2 = red; n is always the complement of p
- tmds_clk_p / tmds_clk_n  out  1  TMDS clock lane

## Operation
- phase counter, 4 bits, counts 0..9 and wraps from 9 to 0 every cycle.
- pixel_stb_o = (phase == 9).
- The load edge is the clk_i edge on which phase == 9. All pixel-rate state changes only on load edges.
- Totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Horizontal counter: x increments on each load edge. x wraps from H_TOTAL-1 to 0.
- Vertical counter: y increments on a load edge only when x == H_TOTAL-1. y wraps from V_TOTAL-1 to 0.
- Derived outputs, combinational from registered x and y:
  - hsync_o = 0 iff x ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - vsync_o = 0 iff y ∈ [490, 491].
  - visible_range_o = (x < H_ACTIVE) && (y < V_ACTIVE).
- Serializer, one 10-bit shift register per data lane:
  - On a load edge, sreg <= tmds word.
  - On any other edge, sreg <= sreg >> 1 (logical shift, zero fill).
  - The serial bit is sreg[0], so word bit 0 goes out first.
- Clock lane: a fourth shift register is loaded with 10'b00000_11111 on every load edge. It outputs high for bits 0-4 and low for bits 5-9.
- Differential stage: on every edge, p <= serial bit and n <= ~serial bit.

## Timing
- Reset asserted (rst_i = 0), effective immediately:
  - phase = 0, x = 0, y = 0, all shift registers = 0.
  - All p outputs = 0, all n outputs = 1.
  - Resulting outputs: hsync_o = 1, vsync_o = 1, visible_range_o = 1, pixel_stb_o = 0.
- After reset release, the first load edge is the 10th rising edge.
- Latency: a word sampled on load edge L appears on the p output as bit k during the cycle following edge L+1+k, for k = 0..9.
- Bit 0 of the next word follows bit 9 of the current word with no gap.
- Line period: 8000 clocks. Frame period: 4,200,000 clocks.
- Input words must be stable around each load edge; they are ignored on all other edges.
- Reset asserted mid-word truncates the word immediately. Output restarts cleanly from phase 0.
- End of frame: at x = 799, y = 524, the next load edge produces x = 0, y = 0 simultaneously.

## Test plan
- Reset check: hold rst_i = 0 → p = 0, n = 1 on all four lanes, x = y = 0, hsync_o = vsync_o = 1. Release reset → pixel_stb_o first high on cycle 9 (0-based), then every 10 cycles.
- Word shape: blue = 10'h2AA, green = 10'h3FF, red = 10'h001 → after latency, lane 0 carries 0,1,0,1,0,1,0,1,0,1. Lane 1 is all ones. Lane 2 is 1 followed by nine 0s. n is the complement of p on every cycle.
- Clock lane: → tmds_clk_p repeats 1,1,1,1,1,0,0,0,0,0, aligned with bit 0 of each data word.
- Line timing:
  - x: 639 → 640 makes visible_range_o fall.
  - hsync_o falls at x = 656 and rises at x = 752.
  - x wraps 799 → 0 and y increments by 1.
- Frame timing: vsync_o is low only for y = 490 and y = 491. y wraps 524 → 0 together with x wrap. visible_range_o is 0 for all y ≥ 480.
- Mid-operation reset: assert rst_i at phase 4 of a word → outputs go to reset values in the same cycle. After release, the first full word arrives with the normal latency.
